// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage: load-mode encodings, FSM states, datapath width.
package mips_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    LM_WORD   = 2'b00,
    LM_HALF_S = 2'b01,
    LM_BYTE_S = 2'b10,
    LM_BYTE_U = 2'b11
  } load_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/load_extract.sv
// Little-endian sub-word selection with sign/zero extension for loads.
module load_extract
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        load_mode_i,
  output logic [DATA_W-1:0] data_o
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  assign half = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    byte_v = rdata_i[7:0];
    unique case (offset_i)
      2'd0: byte_v = rdata_i[7:0];
      2'd1: byte_v = rdata_i[15:8];
      2'd2: byte_v = rdata_i[23:16];
      2'd3: byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
  end

  always_comb begin
    data_o = '0;
    unique case (load_mode_e'(load_mode_i))
      LM_WORD:   data_o = rdata_i;
      LM_HALF_S: data_o = {{(DATA_W-16){half[15]}}, half};
      LM_BYTE_S: data_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LM_BYTE_U: data_o = {{(DATA_W-8){1'b0}}, byte_v};
      default:   data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: dmem req/ack handshake with timeout, load extraction, MEM/WB register.
// Optional MEM_STAGE_ALIGN_CHECK_EN adds a registered misalign flag and suppresses misaligned accesses.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = mips_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              MemToReg_in,
  input  logic              branch_in,
  input  logic              zero_in,
  input  logic [31:0]       pc_in,
  input  logic [DATA_W-1:0] aluResult_in,
  input  logic [DATA_W-1:0] rt_in,
  input  logic [4:0]        writebackDestination_in,
  input  logic [1:0]        load_mode_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              pc_src,
  output logic [31:0]       branch_target,
  output logic              bus_err,
  output logic              RegWrite_wb,
  output logic              MemToReg_wb,
  output logic [DATA_W-1:0] memData_wb,
  output logic [DATA_W-1:0] aluResult_wb,
  output logic [4:0]        writebackDestination_wb
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              bus_err_q;
  logic              mem_op, is_load, misalign_c, mem_go;
  logic              timeout, done, req;
  logic [DATA_W-1:0] rdata_eff, load_data;

  assign mem_op  = MemRead_in | MemWrite_in;
  // Read+write together is treated as a store.
  assign is_load = MemRead_in & ~MemWrite_in;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  always_comb begin
    misalign_c = 1'b0;
    if (MemWrite_in) begin
      misalign_c = |aluResult_in[1:0];
    end else if (MemRead_in) begin
      unique case (load_mode_e'(load_mode_in))
        LM_WORD:   misalign_c = |aluResult_in[1:0];
        LM_HALF_S: misalign_c = aluResult_in[0];
        default:   misalign_c = 1'b0;
      endcase
    end
  end
`else
  assign misalign_c = 1'b0;
`endif

  assign mem_go  = mem_op & ~misalign_c;
  assign timeout = (state_q == ST_WAIT) && (cnt_q == CntW'(TIMEOUT)) && !dmem_ack;
  assign done    = dmem_ack | timeout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req = mem_go;
        if (mem_go && !dmem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = CntW'(1);
        end
      end
      ST_WAIT: begin
        req   = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs drop combinationally while reset is held so an abandoned access ends at once.
  assign dmem_req      = req & ~rst;
  assign dmem_we       = MemWrite_in & dmem_req;
  assign dmem_addr     = {aluResult_in[DATA_W-1:2], 2'b00};
  assign dmem_wdata    = rt_in;
  assign stall         = mem_go & ~done & ~rst;
  assign pc_src        = branch_in & zero_in & ~rst;
  assign branch_target = pc_in;
  assign bus_err       = bus_err_q;

  assign rdata_eff = timeout ? '0 : dmem_rdata;

  load_extract #(
    .DATA_W(DATA_W)
  ) u_load_extract (
    .rdata_i    (rdata_eff),
    .offset_i   (aluResult_in[1:0]),
    .load_mode_i(load_mode_in),
    .data_o     (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                 <= ST_IDLE;
      cnt_q                   <= '0;
      bus_err_q               <= 1'b0;
      RegWrite_wb             <= 1'b0;
      MemToReg_wb             <= 1'b0;
      memData_wb              <= '0;
      aluResult_wb            <= '0;
      writebackDestination_wb <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (timeout) begin
        bus_err_q <= 1'b1;
      end
      if (stall) begin
        RegWrite_wb <= 1'b0;
        MemToReg_wb <= 1'b0;
      end else begin
        RegWrite_wb             <= RegWrite_in & ~misalign_c;
        MemToReg_wb             <= MemToReg_in & ~misalign_c;
        memData_wb              <= (is_load && !misalign_c) ? load_data : '0;
        aluResult_wb            <= aluResult_in;
        writebackDestination_wb <= writebackDestination_in;
      end
    end
  end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= misalign_c;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, timeout/reset sequences, random loads/stores.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, branch_in, zero_in;
  logic [31:0] pc_in, aluResult_in, rt_in;
  logic [4:0]  writebackDestination_in;
  logic [1:0]  load_mode_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, pc_src, bus_err;
  logic [31:0] branch_target;
  logic        RegWrite_wb, MemToReg_wb;
  logic [31:0] memData_wb, aluResult_wb;
  logic [4:0]  writebackDestination_wb;

  int errors = 0;
  int checks = 0;

  mem_stage #(
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .RegWrite_in            (RegWrite_in),
    .MemWrite_in            (MemWrite_in),
    .MemRead_in             (MemRead_in),
    .MemToReg_in            (MemToReg_in),
    .branch_in              (branch_in),
    .zero_in                (zero_in),
    .pc_in                  (pc_in),
    .aluResult_in           (aluResult_in),
    .rt_in                  (rt_in),
    .writebackDestination_in(writebackDestination_in),
    .load_mode_in           (load_mode_in),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .dmem_rdata             (dmem_rdata),
    .dmem_ack               (dmem_ack),
    .stall                  (stall),
    .pc_src                 (pc_src),
    .branch_target          (branch_target),
    .bus_err                (bus_err),
    .RegWrite_wb            (RegWrite_wb),
    .MemToReg_wb            (MemToReg_wb),
    .memData_wb             (memData_wb),
    .aluResult_wb           (aluResult_wb),
    .writebackDestination_wb(writebackDestination_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, rw, m2r;
    logic [1:0]  mode;
    logic [31:0] addr, rdata, rt;
    int          delay;
    logic [31:0] exp_data;
    logic        exp_rw;
    int          exp_stalls;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0; MemToReg_in = 0;
    branch_in = 0; zero_in = 0; pc_in = 0; aluResult_in = 0; rt_in = 0;
    writebackDestination_in = 0; load_mode_in = 0; dmem_rdata = 0; dmem_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load result from byte-lane arithmetic on the read word.
  function automatic logic [31:0] ref_load(input logic [1:0] mode, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int unsigned off, h, b;
    off = addr % 4;
    h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    b = (rdata >> (8 * off)) & 32'hFF;
    case (mode)
      2'd0:    return rdata;
      2'd1:    return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
      2'd2:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      default: return b;
    endcase
  endfunction

  // Presents one instruction, drives ack after 'delay' cycles, returns the number of stall cycles.
  task automatic run_access(input logic rd, input logic wr, input logic rw, input logic m2r,
                            input logic [1:0] mode, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] rt, input int delay,
                            output int stalls);
    int c;
    bit fin;
    logic [4:0] dest;
    dest = addr[4:0] ^ 5'h15;
    MemRead_in = rd; MemWrite_in = wr; RegWrite_in = rw; MemToReg_in = m2r;
    load_mode_in = mode; aluResult_in = addr; dmem_rdata = rdata; rt_in = rt;
    writebackDestination_in = dest;
    stalls = 0; fin = 0; c = 0;
    while (!fin && c < 20) begin
      dmem_ack = (c == delay);
      #2;
      if (c == 0) begin
        chk("dmem_req", dmem_req, rd | wr);
        if (rd | wr) begin
          chk("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
          chk("dmem_we", dmem_we, wr);
          chk("dmem_wdata", dmem_wdata, rt);
        end
      end
      if (!stall) fin = 1;
      else stalls++;
      tick();
      if (!fin) chk("bubble_regwrite", RegWrite_wb, 0);
      c++;
    end
    dmem_ack = 0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL access_bound: stall still high after %0d cycles, required release", c);
    end
    chk("wb_dest", writebackDestination_wb, dest);
    chk("wb_alu", aluResult_wb, addr);
  endtask

  initial begin
    int st;
    logic rd, wr, rw;
    logic [1:0] mode;
    logic [31:0] addr, rdata, rt;
    int dly;

    vecs[0] = '{1,0,1,1, 2'd0, 32'h104, 32'hDEADBEEF, 32'h0,        0, 32'hDEADBEEF, 1, 0};
    vecs[1] = '{1,0,1,1, 2'd2, 32'h203, 32'h80112233, 32'h0,        3, 32'hFFFFFF80, 1, 3};
    vecs[2] = '{1,0,1,1, 2'd3, 32'h203, 32'h80112233, 32'h0,        3, 32'h00000080, 1, 3};
    vecs[3] = '{1,0,1,1, 2'd1, 32'h302, 32'h7FFF8000, 32'h0,        1, 32'h00007FFF, 1, 1};
    vecs[4] = '{1,0,1,1, 2'd1, 32'h300, 32'h7FFF8000, 32'h0,        2, 32'hFFFF8000, 1, 2};
    vecs[5] = '{0,1,0,0, 2'd0, 32'h40,  32'hCAFEF00D, 32'h12345678, 1, 32'h0,        0, 1};
    vecs[6] = '{0,0,1,0, 2'd0, 32'h55,  32'hFFFFFFFF, 32'h0,        0, 32'h0,        1, 0};

    idle_inputs();
    rst = 1;
    #12;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_regwrite", RegWrite_wb, 0);
    chk("rst_memdata", memData_wb, 0);
    chk("rst_alu", aluResult_wb, 0);
    @(posedge clk);
    #1;
    rst = 0;

    foreach (vecs[i]) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].rw, vecs[i].m2r, vecs[i].mode, vecs[i].addr,
                 vecs[i].rdata, vecs[i].rt, vecs[i].delay, st);
      chk($sformatf("vec%0d_stalls", i), st, vecs[i].exp_stalls);
      chk($sformatf("vec%0d_memdata", i), memData_wb, vecs[i].exp_data);
      chk($sformatf("vec%0d_regwrite", i), RegWrite_wb, vecs[i].exp_rw);
      chk($sformatf("vec%0d_memtoreg", i), MemToReg_wb, vecs[i].m2r);
      idle_inputs();
    end

    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 3);
      rd = (op == 1) || (op == 3);
      wr = (op == 2) || (op == 3);
      rw = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      addr = $urandom; rdata = $urandom; rt = $urandom;
      dly = $urandom_range(0, 3);
      run_access(rd, wr, rw, rd, mode, addr, rdata, rt, dly, st);
      chk("rnd_stalls", st, (rd | wr) ? dly : 0);
      chk("rnd_memdata", memData_wb, (rd & ~wr) ? ref_load(mode, addr, rdata) : 32'h0);
      chk("rnd_regwrite", RegWrite_wb, rw);
      chk("rnd_bus_err", bus_err, 0);
      idle_inputs();
    end

    chk("pre_to_bus_err", bus_err, 0);
    run_access(1, 0, 1, 1, 2'd0, 32'h10, 32'hAAAA5555, 32'h0, 1000, st);
    chk("to_stalls", st, TO);
    chk("to_memdata", memData_wb, 0);
    chk("to_bus_err", bus_err, 1);
    chk("to_regwrite", RegWrite_wb, 1);
    idle_inputs();
    run_access(1, 0, 1, 1, 2'd0, 32'h14, 32'h0BADF00D, 32'h0, 0, st);
    chk("post_to_memdata", memData_wb, 32'h0BADF00D);
    chk("bus_err_sticky", bus_err, 1);
    idle_inputs();

    branch_in = 1; zero_in = 0; pc_in = 32'h80;
    #2;
    chk("pc_src_not_taken", pc_src, 0);
    zero_in = 1;
    #1;
    chk("pc_src_taken", pc_src, 1);
    chk("branch_target", branch_target, 32'h80);
    tick();

    MemRead_in = 1; RegWrite_in = 1; aluResult_in = 32'h500; dmem_rdata = 32'h1;
    #2;
    chk("wait_stall0", stall, 1);
    tick();
    tick();
    chk("wait_req", dmem_req, 1);
    chk("wait_stall", stall, 1);
    chk("wait_pc_src", pc_src, 1);
    rst = 1;
    #1;
    chk("midrst_req", dmem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_pc_src", pc_src, 0);
    chk("midrst_bus_err", bus_err, 0);
    chk("midrst_memdata", memData_wb, 0);
    chk("midrst_alu", aluResult_wb, 0);
    chk("midrst_dest", writebackDestination_wb, 0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 0;
    dmem_ack = 1;
    #2;
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_stall", stall, 0);
    tick();
    chk("late_ack_regwrite", RegWrite_wb, 0);
    dmem_ack = 0;
    run_access(1, 0, 1, 1, 2'd3, 32'h601, 32'h0000C300, 32'h0, 0, st);
    chk("post_rst_stalls", st, 0);
    chk("post_rst_memdata", memData_wb, 32'h000000C3);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
